// File: rtl/simple_cpu_pkg.sv
// Shared types for the simple CPU datapath: register index and write-back entry.
package simple_cpu_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t            idx;
    logic [DATA_W-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/reg_write_arbiter_if.sv
// Write-back bus between the ALU/load producers, the register file write port and operand fetch.
interface reg_write_arbiter_if #(parameter int DEPTH = 4);
  import simple_cpu_pkg::*;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                alu_valid;
  logic                alu_ready;
  reg_idx_t            alu_reg;
  logic [DATA_W-1:0]   alu_data;
  logic                mem_valid;
  logic                mem_ready;
  reg_idx_t            mem_reg;
  logic [DATA_W-1:0]   mem_data;
  logic                reg_write;
  reg_idx_t            write_register;
  logic [DATA_W-1:0]   write_data;
  reg_idx_t            rs;
  reg_idx_t            rd;
  logic                fwd_a_hit;
  logic [DATA_W-1:0]   fwd_a_data;
  logic                fwd_b_hit;
  logic [DATA_W-1:0]   fwd_b_data;
  logic [CNT_W-1:0]    pending_count;
  logic                busy;

  modport slave (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, rs, rd,
    output alu_ready, mem_ready, reg_write, write_register, write_data,
           fwd_a_hit, fwd_a_data, fwd_b_hit, fwd_b_data, pending_count, busy
  );

  modport master (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, rs, rd,
    input  alu_ready, mem_ready, reg_write, write_register, write_data,
           fwd_a_hit, fwd_a_data, fwd_b_hit, fwd_b_data, pending_count, busy
  );
endinterface

// File: rtl/fwd_lookup.sv
// Finds the youngest valid entry matching a read address; entries[0] is oldest.
module fwd_lookup
  import simple_cpu_pkg::*;
#(
  parameter int N = 5
) (
  input  wb_entry_t [N-1:0]  entries,
  input  logic [N-1:0]       validMask,
  input  reg_idx_t           addr,
  output logic               hit,
  output logic [DATA_W-1:0]  data
);
  logic match_s;

  // Scan oldest to youngest so the last match overrides earlier ones.
  always_comb begin
    hit     = 1'b0;
    data    = {DATA_W{1'b0}};
    match_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      match_s = validMask[i] & (entries[i].idx == addr);
      hit     = hit | match_s;
      data    = match_s ? entries[i].data : data;
    end
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// Merges ALU and load write-backs into an in-order queue feeding the register file write port,
// and forwards not-yet-committed values to the two read ports.
module reg_write_arbiter
  import simple_cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                 clock,
  input logic                 reset_n,
  reg_write_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NSLOT = DEPTH + 1;

  wb_entry_t          queue_r [DEPTH];
  logic [PTR_W-1:0]   head_r;
  logic [PTR_W-1:0]   tail_r;
  logic [CNT_W-1:0]   count_r;
  logic               regWrite_r;
  reg_idx_t           writeReg_r;
  logic [DATA_W-1:0]  writeData_r;

  logic               pop_s;
  logic [CNT_W:0]     free_s;
  logic               memReady_s;
  logic               aluReady_s;
  logic               memAcc_s;
  logic               aluAcc_s;
  logic [PTR_W-1:0]   aluSlot_s;

  wb_entry_t [NSLOT-1:0] ordered_s;
  logic [NSLOT-1:0]      orderedValid_s;
  logic                  fwdAHit_s;
  logic                  fwdBHit_s;
  logic [DATA_W-1:0]     fwdAData_s;
  logic [DATA_W-1:0]     fwdBData_s;

  // Acceptance: load wins the last free slot; readiness never depends on alu_valid.
  always_comb begin
    pop_s      = (count_r != {CNT_W{1'b0}});
    free_s     = (CNT_W+1)'(DEPTH) - {1'b0, count_r} + (CNT_W+1)'(pop_s);
    memReady_s = (free_s >= (CNT_W+1)'(1));
    aluReady_s = (free_s >= (CNT_W+1)'(2)) | ((free_s == (CNT_W+1)'(1)) & ~bus.mem_valid);
    memAcc_s   = bus.mem_valid & memReady_s;
    aluAcc_s   = bus.alu_valid & aluReady_s;
    aluSlot_s  = memAcc_s ? (tail_r + PTR_W'(1)) : tail_r;
  end

  // Queue storage; a same-cycle pair lands load first (older), then ALU.
  always_ff @(posedge clock) begin
    if (memAcc_s) begin
      queue_r[tail_r] <= '{idx: bus.mem_reg, data: bus.mem_data};
    end
    if (aluAcc_s) begin
      queue_r[aluSlot_s] <= '{idx: bus.alu_reg, data: bus.alu_data};
    end
  end

  // Pointers, occupancy and the registered write-port stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_r      <= {PTR_W{1'b0}};
      tail_r      <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      regWrite_r  <= 1'b0;
      writeReg_r  <= {ADDR_W{1'b0}};
      writeData_r <= {DATA_W{1'b0}};
    end else begin
      head_r  <= head_r + PTR_W'(pop_s);
      tail_r  <= tail_r + PTR_W'(memAcc_s) + PTR_W'(aluAcc_s);
      count_r <= count_r - CNT_W'(pop_s) + CNT_W'(memAcc_s) + CNT_W'(aluAcc_s);
      if (pop_s) begin
        regWrite_r  <= 1'b1;
        writeReg_r  <= queue_r[head_r].idx;
        writeData_r <= queue_r[head_r].data;
      end else begin
        regWrite_r  <= 1'b0;
      end
    end
  end

  // Age-ordered view: output stage is oldest, then queue entries from head.
  always_comb begin
    ordered_s[0]      = '{idx: writeReg_r, data: writeData_r};
    orderedValid_s[0] = regWrite_r;
    for (int i = 0; i < DEPTH; i++) begin
      ordered_s[i+1]      = queue_r[head_r + PTR_W'(i)];
      orderedValid_s[i+1] = (CNT_W'(i) < count_r);
    end
  end

  fwd_lookup #(.N(NSLOT)) fwdA (
    .entries   (ordered_s),
    .validMask (orderedValid_s),
    .addr      (bus.rs),
    .hit       (fwdAHit_s),
    .data      (fwdAData_s)
  );

  fwd_lookup #(.N(NSLOT)) fwdB (
    .entries   (ordered_s),
    .validMask (orderedValid_s),
    .addr      (bus.rd),
    .hit       (fwdBHit_s),
    .data      (fwdBData_s)
  );

  assign bus.alu_ready      = aluReady_s;
  assign bus.mem_ready      = memReady_s;
  assign bus.reg_write      = regWrite_r;
  assign bus.write_register = writeReg_r;
  assign bus.write_data     = writeData_r;
  assign bus.fwd_a_hit      = fwdAHit_s;
  assign bus.fwd_a_data     = fwdAData_s;
  assign bus.fwd_b_hit      = fwdBHit_s;
  assign bus.fwd_b_data     = fwdBData_s;
  assign bus.pending_count  = count_r;
  assign bus.busy           = pop_s | regWrite_r;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed and randomized checks of the write-back arbiter against hand-computed values and a queue model.
module tb_reg_write_arbiter;
  import simple_cpu_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  reg_write_arbiter_if bus();

  reg_write_arbiter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checkCount = 0;
  int errorCount = 0;

  reg_idx_t    logReg[$];
  logic [15:0] logData[$];
  reg_idx_t    expReg[$];
  logic [15:0] expData[$];

  reg_idx_t    mqReg[$];
  logic [15:0] mqData[$];
  logic        mOutValid;
  reg_idx_t    mOutReg;
  logic [15:0] mOutData;

  always @(negedge clock) begin
    if (bus.reg_write === 1'b1) begin
      logReg.push_back(bus.write_register);
      logData.push_back(bus.write_data);
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic av, input logic [2:0] ar, input logic [15:0] ad,
                       input logic mv, input logic [2:0] mr, input logic [15:0] md);
    bus.alu_valid = av;
    bus.alu_reg   = ar;
    bus.alu_data  = ad;
    bus.mem_valid = mv;
    bus.mem_reg   = mr;
    bus.mem_data  = md;
  endtask

  task automatic expectWrite(input logic [2:0] r, input logic [15:0] d);
    expReg.push_back(r);
    expData.push_back(d);
  endtask

  task automatic checkWrites(input string tag, input int base);
    checkVal({tag, "_count"}, 32'(logReg.size() - base), 32'(expReg.size()));
    for (int i = 0; i < expReg.size(); i++) begin
      if (base + i < logReg.size()) begin
        checkVal({tag, "_reg"}, 32'(logReg[base+i]), 32'(expReg[i]));
        checkVal({tag, "_data"}, 32'(logData[base+i]), 32'(expData[i]));
      end
    end
    expReg.delete();
    expData.delete();
  endtask

  function automatic void fwdModel(input logic [2:0] a, output logic h, output logic [15:0] d);
    h = 1'b0;
    d = 16'h0000;
    if (mOutValid && mOutReg == a) begin
      h = 1'b1;
      d = mOutData;
    end
    foreach (mqReg[i]) begin
      if (mqReg[i] == a) begin
        h = 1'b1;
        d = mqData[i];
      end
    end
  endfunction

  initial begin
    int base;
    logic av, mv, eh, eMem, eAlu, mPop;
    logic [2:0] ar, mr;
    logic [15:0] ad, md, ed;
    int freeM;

    reset_n = 1'b0;
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    bus.rs = 3'd0;
    bus.rd = 3'd0;
    repeat (2) @(posedge clock);
    #1;
    checkVal("rst_reg_write", 32'(bus.reg_write), 32'd0);
    checkVal("rst_write_register", 32'(bus.write_register), 32'd0);
    checkVal("rst_write_data", 32'(bus.write_data), 32'd0);
    checkVal("rst_pending", 32'(bus.pending_count), 32'd0);
    checkVal("rst_busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;
    step();

    // single ALU write r3
    drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0000);
    #1;
    checkVal("single_alu_ready", 32'(bus.alu_ready), 32'd1);
    step();
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    checkVal("single_pending", 32'(bus.pending_count), 32'd1);
    checkVal("single_rw_early", 32'(bus.reg_write), 32'd0);
    step();
    checkVal("single_rw", 32'(bus.reg_write), 32'd1);
    checkVal("single_wreg", 32'(bus.write_register), 32'd3);
    checkVal("single_wdata", 32'(bus.write_data), 32'h1234);
    checkVal("single_busy", 32'(bus.busy), 32'd1);
    step();
    checkVal("single_rw_low", 32'(bus.reg_write), 32'd0);
    checkVal("single_wreg_hold", 32'(bus.write_register), 32'd3);
    checkVal("single_idle", 32'(bus.busy), 32'd0);

    // collision: mem is older than alu
    drive(1'b1, 3'd1, 16'h0001, 1'b1, 3'd2, 16'h0002);
    #1;
    checkVal("coll_alu_ready", 32'(bus.alu_ready), 32'd1);
    checkVal("coll_mem_ready", 32'(bus.mem_ready), 32'd1);
    step();
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    checkVal("coll_pending", 32'(bus.pending_count), 32'd2);
    step();
    checkVal("coll_rw1", 32'(bus.reg_write), 32'd1);
    checkVal("coll_wreg1", 32'(bus.write_register), 32'd2);
    checkVal("coll_wdata1", 32'(bus.write_data), 32'h0002);
    step();
    checkVal("coll_rw2", 32'(bus.reg_write), 32'd1);
    checkVal("coll_wreg2", 32'(bus.write_register), 32'd1);
    checkVal("coll_wdata2", 32'(bus.write_data), 32'h0001);
    step();
    checkVal("coll_rw_low", 32'(bus.reg_write), 32'd0);

    // full: four back-to-back loads, ALU held valid (r0 writes are legal)
    base = logReg.size();
    drive(1'b1, 3'd0, 16'hA000, 1'b1, 3'd4, 16'h4000);
    #1;
    checkVal("full_c1_mem_ready", 32'(bus.mem_ready), 32'd1);
    checkVal("full_c1_alu_ready", 32'(bus.alu_ready), 32'd1);
    step();
    drive(1'b1, 3'd0, 16'hA001, 1'b1, 3'd5, 16'h4001);
    #1;
    checkVal("full_c2_pending", 32'(bus.pending_count), 32'd2);
    checkVal("full_c2_alu_ready", 32'(bus.alu_ready), 32'd1);
    step();
    drive(1'b1, 3'd0, 16'hA002, 1'b1, 3'd6, 16'h4002);
    #1;
    checkVal("full_c3_pending", 32'(bus.pending_count), 32'd3);
    checkVal("full_c3_alu_ready", 32'(bus.alu_ready), 32'd1);
    step();
    drive(1'b1, 3'd0, 16'hA003, 1'b1, 3'd7, 16'h4003);
    #1;
    checkVal("full_c4_pending", 32'(bus.pending_count), 32'd4);
    checkVal("full_c4_mem_ready", 32'(bus.mem_ready), 32'd1);
    checkVal("full_c4_alu_ready", 32'(bus.alu_ready), 32'd0);
    step();
    bus.mem_valid = 1'b0;
    #1;
    checkVal("full_c5_pending", 32'(bus.pending_count), 32'd4);
    checkVal("full_c5_alu_ready", 32'(bus.alu_ready), 32'd1);
    step();
    bus.alu_valid = 1'b0;
    repeat (8) step();
    checkVal("full_drained", 32'(bus.pending_count), 32'd0);
    expectWrite(3'd4, 16'h4000); expectWrite(3'd0, 16'hA000);
    expectWrite(3'd5, 16'h4001); expectWrite(3'd0, 16'hA001);
    expectWrite(3'd6, 16'h4002); expectWrite(3'd0, 16'hA002);
    expectWrite(3'd7, 16'h4003); expectWrite(3'd0, 16'hA003);
    checkWrites("full_order", base);

    // forwarding: r5 written twice, newest value wins
    bus.rs = 3'd5;
    bus.rd = 3'd6;
    drive(1'b1, 3'd5, 16'hAAAA, 1'b0, 3'd0, 16'h0000);
    #1;
    checkVal("fwd_empty_hit", 32'(bus.fwd_a_hit), 32'd0);
    step();
    drive(1'b1, 3'd5, 16'hBBBB, 1'b0, 3'd0, 16'h0000);
    #1;
    checkVal("fwd_q1_hit", 32'(bus.fwd_a_hit), 32'd1);
    checkVal("fwd_q1_data", 32'(bus.fwd_a_data), 32'hAAAA);
    step();
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    #1;
    checkVal("fwd_q2_hit", 32'(bus.fwd_a_hit), 32'd1);
    checkVal("fwd_q2_data", 32'(bus.fwd_a_data), 32'hBBBB);
    checkVal("fwd_b_hit", 32'(bus.fwd_b_hit), 32'd0);
    checkVal("fwd_b_data", 32'(bus.fwd_b_data), 32'd0);
    step();
    checkVal("fwd_out_hit", 32'(bus.fwd_a_hit), 32'd1);
    checkVal("fwd_out_data", 32'(bus.fwd_a_data), 32'hBBBB);
    step();
    checkVal("fwd_done_hit", 32'(bus.fwd_a_hit), 32'd0);
    checkVal("fwd_done_data", 32'(bus.fwd_a_data), 32'd0);

    // reset mid-traffic with three entries queued
    drive(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222);
    step();
    drive(1'b1, 3'd3, 16'h3333, 1'b1, 3'd4, 16'h4444);
    step();
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    #1;
    checkVal("rst_mid_pending_before", 32'(bus.pending_count), 32'd3);
    reset_n = 1'b0;
    #1;
    checkVal("rst_mid_rw", 32'(bus.reg_write), 32'd0);
    checkVal("rst_mid_pending", 32'(bus.pending_count), 32'd0);
    step();
    checkVal("rst_mid_rw_next", 32'(bus.reg_write), 32'd0);
    base = logReg.size();
    reset_n = 1'b1;
    repeat (5) step();
    checkVal("rst_mid_no_write", 32'(logReg.size() - base), 32'd0);
    checkVal("rst_mid_busy", 32'(bus.busy), 32'd0);

    // randomized traffic against a queue model
    mOutValid = 1'b0;
    mOutReg   = 3'd0;
    mOutData  = 16'h0000;
    for (int c = 0; c < 400; c++) begin
      av = ($urandom_range(0, 3) != 0);
      mv = ($urandom_range(0, 3) != 0);
      ar = 3'($urandom_range(0, 7));
      mr = 3'($urandom_range(0, 7));
      ad = 16'($urandom);
      md = 16'($urandom);
      drive(av, ar, ad, mv, mr, md);
      bus.rs = 3'($urandom_range(0, 7));
      bus.rd = 3'($urandom_range(0, 7));
      #1;
      mPop  = (mqReg.size() != 0);
      freeM = 4 - mqReg.size() + (mPop ? 1 : 0);
      eMem  = (freeM >= 1);
      eAlu  = (freeM >= 2) || (freeM == 1 && !mv);
      checkVal("rnd_mem_ready", 32'(bus.mem_ready), 32'(eMem));
      checkVal("rnd_alu_ready", 32'(bus.alu_ready), 32'(eAlu));
      checkVal("rnd_pending", 32'(bus.pending_count), 32'(mqReg.size()));
      checkVal("rnd_reg_write", 32'(bus.reg_write), 32'(mOutValid));
      if (mOutValid) begin
        checkVal("rnd_wreg", 32'(bus.write_register), 32'(mOutReg));
        checkVal("rnd_wdata", 32'(bus.write_data), 32'(mOutData));
      end
      fwdModel(bus.rs, eh, ed);
      checkVal("rnd_fwd_a_hit", 32'(bus.fwd_a_hit), 32'(eh));
      checkVal("rnd_fwd_a_data", 32'(bus.fwd_a_data), 32'(ed));
      fwdModel(bus.rd, eh, ed);
      checkVal("rnd_fwd_b_hit", 32'(bus.fwd_b_hit), 32'(eh));
      checkVal("rnd_fwd_b_data", 32'(bus.fwd_b_data), 32'(ed));
      if (mPop) begin
        mOutReg   = mqReg.pop_front();
        mOutData  = mqData.pop_front();
        mOutValid = 1'b1;
      end else begin
        mOutValid = 1'b0;
      end
      if (mv && eMem) begin
        mqReg.push_back(mr);
        mqData.push_back(md);
      end
      if (av && eAlu) begin
        mqReg.push_back(ar);
        mqData.push_back(ad);
      end
      step();
    end

    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
